hazard_ctrl: RTL and testbench

- Consumer side of the Tuse/Tnew hazard interface in the 5-stage MIPS pipeline (F/D/E/M/W).
- Takes D-stage operand Tuse values and destination info from the decode side.
- Internally tracks destination register and Tnew of the instructions in E, M and W.
- Produces the global stall and every forwarding-mux select; keeps a stall counter for performance checks.

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_fwd_sel.sv | 43 ++++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared Tuse/Tnew constants, forward-select encodings and a
//                saturating Tnew decrement for the MIPS hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Tnew values an instruction carries into E, per producer class
  localparam int T_ALU = 1;   // addu/subu/ori/lui
  localparam int T_DM  = 2;   // lw
  localparam int T_PC  = 0;   // jal

  // Tuse value meaning "operand not read"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Forwarding mux select encodings
  localparam logic [1:0] FW_RF = 2'd0;
  localparam logic [1:0] FW_E  = 2'd1;
  localparam logic [1:0] FW_M  = 2'd2;
  localparam logic [1:0] FW_W  = 2'd3;

  // Tnew shrinks by one per stage advanced, floored at zero
  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x != 2'd0) ? (x - 2'd1) : 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_sel
//  Description : Combinational priority forward select for one operand
//                address against the E/M/W writers (E > M > W).
//  Ports       : i_addr          operand register address
//                i_a3_e/i_rdy_e  E destination / E may forward now
//                i_a3_m/i_rdy_m  M destination / M may forward now
//                i_a3_w/i_rdy_w  W destination / W may forward now
//                o_sel           FW_RF / FW_E / FW_M / FW_W
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_addr,
  input  logic [4:0] i_a3_e,
  input  logic       i_rdy_e,
  input  logic [4:0] i_a3_m,
  input  logic       i_rdy_m,
  input  logic [4:0] i_a3_w,
  input  logic       i_rdy_w,
  output logic [1:0] o_sel
);

  logic w_hit_e;
  logic w_hit_m;
  logic w_hit_w;

  // rdy already excludes $0 writers, so a match implies i_addr != 0
  assign w_hit_e = i_rdy_e && (i_a3_e == i_addr);
  assign w_hit_m = i_rdy_m && (i_a3_m == i_addr);
  assign w_hit_w = i_rdy_w && (i_a3_w == i_addr);

  always_comb begin
    o_sel = FW_RF;
    if (w_hit_e)      o_sel = FW_E;
    else if (w_hit_m) o_sel = FW_M;
    else if (w_hit_w) o_sel = FW_W;
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Tuse/Tnew hazard controller for a 5-stage MIPS pipeline.
//                Tracks E/M/W destinations, raises the global stall and
//                drives every forwarding select; counts stall cycles.
//  Ports       : clk, reset (async, active-high)
//                rs_d/rt_d, tuse_rs/tuse_rt   D operands and their Tuse
//                a3_d/we_d/tnew_d             D destination info
//                stall                        freeze PC/FD, bubble DE
//                fwd_rs_d/fwd_rt_d            D compare operand selects
//                fwd_rs_e/fwd_rt_e            E ALU operand selects
//                fwd_rt_m                     M store data select
//                stall_cnt                    saturating stall counter
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int T_ALU = 1,
  parameter int T_DM  = 2,
  parameter int T_PC  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [1:0]       tuse_rs,
  input  logic [1:0]       tuse_rt,
  input  logic [4:0]       a3_d,
  input  logic             we_d,
  input  logic [1:0]       tnew_d,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic [1:0]       fwd_rt_m,
  output logic [CNT_W-1:0] stall_cnt
);

  import hazard_ctrl_pkg::*;

  // Largest Tnew any producer class can carry; larger tnew_d is not a legal
  // encoding and is clamped so it cannot stall longer than a real producer.
  localparam int TNEW_MAX_I = (T_DM > T_ALU) ? ((T_DM > T_PC) ? T_DM : T_PC)
                                             : ((T_ALU > T_PC) ? T_ALU : T_PC);
  localparam logic [1:0]       TNEW_MAX = TNEW_MAX_I[1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Tracking registers
  logic [4:0]       r_a3_e, r_rs_e, r_rt_e;
  logic             r_we_e;
  logic [1:0]       r_tnew_e;
  logic [4:0]       r_a3_m, r_rt_m;
  logic             r_we_m;
  logic [1:0]       r_tnew_m;
  logic [4:0]       r_a3_w;
  logic             r_we_w;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_wr_e, w_wr_m, w_wr_w;
  logic       w_rdy_e, w_rdy_m;
  logic       w_stall_rs, w_stall_rt, w_stall;
  logic [1:0] w_tnew_in;

  assign w_wr_e  = r_we_e && (r_a3_e != 5'd0);
  assign w_wr_m  = r_we_m && (r_a3_m != 5'd0);
  assign w_wr_w  = r_we_w && (r_a3_w != 5'd0);
  assign w_rdy_e = w_wr_e && (r_tnew_e == 2'd0);
  assign w_rdy_m = w_wr_m && (r_tnew_m == 2'd0);

  assign w_tnew_in = (tnew_d > TNEW_MAX) ? TNEW_MAX : tnew_d;

  // A producer stalls D when its result is ready later than D needs it
  assign w_stall_rs = (rs_d != 5'd0) && (tuse_rs != TUSE_NONE) &&
                      ((w_wr_e && (r_a3_e == rs_d) && (r_tnew_e > tuse_rs)) ||
                       (w_wr_m && (r_a3_m == rs_d) && (r_tnew_m > tuse_rs)));
  assign w_stall_rt = (rt_d != 5'd0) && (tuse_rt != TUSE_NONE) &&
                      ((w_wr_e && (r_a3_e == rt_d) && (r_tnew_e > tuse_rt)) ||
                       (w_wr_m && (r_a3_m == rt_d) && (r_tnew_m > tuse_rt)));
  assign w_stall    = w_stall_rs || w_stall_rt;

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a3_e      <= 5'd0;
      r_rs_e      <= 5'd0;
      r_rt_e      <= 5'd0;
      r_we_e      <= 1'b0;
      r_tnew_e    <= 2'd0;
      r_a3_m      <= 5'd0;
      r_rt_m      <= 5'd0;
      r_we_m      <= 1'b0;
      r_tnew_m    <= 2'd0;
      r_a3_w      <= 5'd0;
      r_we_w      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_a3_e   <= 5'd0;
        r_rs_e   <= 5'd0;
        r_rt_e   <= 5'd0;
        r_we_e   <= 1'b0;
        r_tnew_e <= 2'd0;
      end else begin
        r_a3_e   <= a3_d;
        r_rs_e   <= rs_d;
        r_rt_e   <= rt_d;
        r_we_e   <= we_d;
        r_tnew_e <= w_tnew_in;
      end
      r_a3_m   <= r_a3_e;
      r_rt_m   <= r_rt_e;
      r_we_m   <= r_we_e;
      r_tnew_m <= sat_dec(r_tnew_e);
      r_a3_w   <= r_a3_m;
      r_we_w   <= r_we_m;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  hazard_fwd_sel u_sel_rs_d (
    .i_addr(rs_d),   .i_a3_e(r_a3_e), .i_rdy_e(w_rdy_e),
    .i_a3_m(r_a3_m), .i_rdy_m(w_rdy_m),
    .i_a3_w(r_a3_w), .i_rdy_w(w_wr_w), .o_sel(fwd_rs_d)
  );

  hazard_fwd_sel u_sel_rt_d (
    .i_addr(rt_d),   .i_a3_e(r_a3_e), .i_rdy_e(w_rdy_e),
    .i_a3_m(r_a3_m), .i_rdy_m(w_rdy_m),
    .i_a3_w(r_a3_w), .i_rdy_w(w_wr_w), .o_sel(fwd_rt_d)
  );

  // E operands can only be fed from M or W
  hazard_fwd_sel u_sel_rs_e (
    .i_addr(r_rs_e), .i_a3_e(5'd0),   .i_rdy_e(1'b0),
    .i_a3_m(r_a3_m), .i_rdy_m(w_rdy_m),
    .i_a3_w(r_a3_w), .i_rdy_w(w_wr_w), .o_sel(fwd_rs_e)
  );

  hazard_fwd_sel u_sel_rt_e (
    .i_addr(r_rt_e), .i_a3_e(5'd0),   .i_rdy_e(1'b0),
    .i_a3_m(r_a3_m), .i_rdy_m(w_rdy_m),
    .i_a3_w(r_a3_w), .i_rdy_w(w_wr_w), .o_sel(fwd_rt_e)
  );

  // Store data in M can only be fed from W
  hazard_fwd_sel u_sel_rt_m (
    .i_addr(r_rt_m), .i_a3_e(5'd0),   .i_rdy_e(1'b0),
    .i_a3_m(5'd0),   .i_rdy_m(1'b0),
    .i_a3_w(r_a3_w), .i_rdy_w(w_wr_w), .o_sel(fwd_rt_m)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [4:0]       rs_d, rt_d, a3_d;
  logic [1:0]       tuse_rs, tuse_rt, tnew_d;
  logic             we_d;
  logic             stall;
  logic [1:0]       fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic [CNT_W-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .a3_d(a3_d), .we_d(we_d), .tnew_d(tnew_d),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a D-stage instruction mid-cycle and let outputs settle
  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] tr, input logic [1:0] tt,
                     input logic [4:0] a3, input logic we, input logic [1:0] tn);
    rs_d = rs; rt_d = rt; tuse_rs = tr; tuse_rt = tt;
    a3_d = a3; we_d = we; tnew_d = tn;
    #1;
  endtask

  task automatic nop();
    drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    nop();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drv(5'd1, 5'd2, 2'd0, 2'd0, 5'd3, 1'b1, 2'd2);
    @(posedge clk); #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_tests++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 10'd0) begin n_fail++; $display("FAIL reset_fwd: got %h want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}); end
    n_tests++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    do_reset();
  endtask

  // lw $1 ; addu $3,$1,$2
  task automatic test_lw_alu();
    do_reset();
    drv(5'd0, 5'd1, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2); next();
    drv(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_alu_stall1: got %0b want 1", stall); end
    next();
    drv(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_alu_stall2: got %0b want 0", stall); end
    n_tests++; if (fwd_rs_d !== 2'd0) begin n_fail++; $display("FAIL lw_alu_fwd_rs_d: got %0d want 0", fwd_rs_d); end
    next();
    nop();
    n_tests++; if (fwd_rs_e !== 2'd3) begin n_fail++; $display("FAIL lw_alu_fwd_rs_e: got %0d want 3", fwd_rs_e); end
    n_tests++; if (fwd_rt_e !== 2'd0) begin n_fail++; $display("FAIL lw_alu_fwd_rt_e: got %0d want 0", fwd_rt_e); end
    n_tests++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lw_alu_cnt: got %0d want 1", stall_cnt); end
    next();
  endtask

  // lw $1 ; beq $1,$0
  task automatic test_lw_branch();
    do_reset();
    drv(5'd0, 5'd1, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2); next();
    for (int i = 0; i < 2; i++) begin
      drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_br_stall%0d: got %0b want 1", i, stall); end
      next();
    end
    drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_br_release: got %0b want 0", stall); end
    n_tests++; if (fwd_rs_d !== 2'd3) begin n_fail++; $display("FAIL lw_br_fwd_rs_d: got %0d want 3", fwd_rs_d); end
    n_tests++; if (fwd_rt_d !== 2'd0) begin n_fail++; $display("FAIL lw_br_fwd_rt_d: got %0d want 0", fwd_rt_d); end
    n_tests++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL lw_br_cnt: got %0d want 2", stall_cnt); end
    next();
  endtask

  // addu $1 ; beq $1,$1
  task automatic test_alu_branch();
    do_reset();
    drv(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 1'b1, 2'd1); next();
    drv(5'd1, 5'd1, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL alu_br_stall: got %0b want 1", stall); end
    next();
    drv(5'd1, 5'd1, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_br_release: got %0b want 0", stall); end
    n_tests++; if (fwd_rs_d !== 2'd2) begin n_fail++; $display("FAIL alu_br_fwd_rs_d: got %0d want 2", fwd_rs_d); end
    n_tests++; if (fwd_rt_d !== 2'd2) begin n_fail++; $display("FAIL alu_br_fwd_rt_d: got %0d want 2", fwd_rt_d); end
    next();
  endtask

  // jal ; jr $31
  task automatic test_jal_jr();
    do_reset();
    drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0); next();
    drv(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jal_jr_stall: got %0b want 0", stall); end
    n_tests++; if (fwd_rs_d !== 2'd1) begin n_fail++; $display("FAIL jal_jr_fwd_rs_d: got %0d want 1", fwd_rs_d); end
    n_tests++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL jal_jr_cnt: got %0d want 0", stall_cnt); end
    next();
  endtask

  // addu $5 ; addu $5 ; sw $5 -> nearest producer wins; then $0 handling
  task automatic test_priority_zero();
    do_reset();
    drv(5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 1'b1, 2'd1); next();
    drv(5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 1'b1, 2'd1); next();
    drv(5'd0, 5'd5, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %0b want 0", stall); end
    next();
    nop();
    n_tests++; if (fwd_rt_e !== 2'd2) begin n_fail++; $display("FAIL sw_fwd_rt_e: got %0d want 2", fwd_rt_e); end
    next();
    nop();
    n_tests++; if (fwd_rt_m !== 2'd3) begin n_fail++; $display("FAIL sw_fwd_rt_m: got %0d want 3", fwd_rt_m); end
    next();
    // write $0 then read $0 in every stage
    drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd1); next();
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b1, 2'd0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %0b want 0", stall); end
    n_tests++; if ({fwd_rs_d, fwd_rt_d} !== 4'd0) begin n_fail++; $display("FAIL zero_fwd_d: got %h want 0", {fwd_rs_d, fwd_rt_d}); end
    next(); nop(); next(); nop();
    n_tests++; if ({fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 6'd0) begin n_fail++; $display("FAIL zero_fwd_em: got %h want 0", {fwd_rs_e, fwd_rt_e, fwd_rt_m}); end
    next();
  endtask

  // lw $1 ; addu $2 ; beq $1,$2 -> rs hazard on M and rt hazard on E together
  task automatic test_dual_hazard();
    do_reset();
    drv(5'd0, 5'd1, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2); next();
    drv(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 1'b1, 2'd1); next();
    drv(5'd1, 5'd2, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL dual_stall: got %0b want 1", stall); end
    next();
    drv(5'd1, 5'd2, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL dual_release: got %0b want 0", stall); end
    n_tests++; if (fwd_rs_d !== 2'd3) begin n_fail++; $display("FAIL dual_fwd_rs_d: got %0d want 3", fwd_rs_d); end
    n_tests++; if (fwd_rt_d !== 2'd2) begin n_fail++; $display("FAIL dual_fwd_rt_d: got %0d want 2", fwd_rt_d); end
    n_tests++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL dual_cnt: got %0d want 1", stall_cnt); end
    next();
  endtask

  // reset asserted during the second stall cycle of lw/beq
  task automatic test_reset_mid_stall();
    do_reset();
    drv(5'd0, 5'd1, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2); next();
    drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0); next();
    drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %0b want 1", stall); end
    reset = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %0b want 0", stall); end
    n_tests++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 10'd0) begin n_fail++; $display("FAIL rst_mid_fwd: got %h want 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}); end
    n_tests++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d want 0", stall_cnt); end
    next();
    reset = 1'b0;
    drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    n_tests++; if ({stall, fwd_rs_d} !== 3'd0) begin n_fail++; $display("FAIL rst_mid_resume: got %h want 0", {stall, fwd_rs_d}); end
    next();
  endtask

  // 9 lw/beq pairs = 18 stall cycles; a 4-bit counter must hold at 15
  task automatic test_cnt_saturate();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drv(5'd0, 5'd1, 2'd1, 2'd3, 5'd1, 1'b1, 2'd2); next();
      drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0); next();
      drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0); next();
      drv(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
      exp_cnt = (2 * (k + 1) > 15) ? 4'd15 : 4'(2 * (k + 1));
      n_tests++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL cnt_sat_%0d: got %0d want %0d", k, stall_cnt, exp_cnt); end
      next();
    end
  endtask

  initial begin
    reset = 1'b1;
    rs_d = 5'd0; rt_d = 5'd0; tuse_rs = 2'd3; tuse_rt = 2'd3;
    a3_d = 5'd0; we_d = 1'b0; tnew_d = 2'd0;
    test_reset();
    test_lw_alu();
    test_lw_branch();
    test_alu_branch();
    test_jal_jr();
    test_priority_zero();
    test_dual_hazard();
    test_reset_mid_stall();
    test_cnt_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
